// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-divider blocks and their monitors.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    ACQ    = 2'd2,
    LOCKED = 2'd3
  } mon_state_t;

  localparam int CNT_W_DEF       = 8;
  localparam int LOCK_CYCLES_DEF = 4;
  localparam int ERR_W_DEF       = 8;

  // Increment that sticks at lim instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/div_edge_detect.sv
// One-cycle history of a clk-synchronous signal with rise/fall/edge strobes.
module div_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o,
  output logic edge_o
);

  logic d_q;

  // Previous-cycle sample; tracks regardless of monitor state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) d_q <= 1'b0;
    else         d_q <= sig_i;
  end

  assign rise_o = sig_i & ~d_q;
  assign fall_o = ~sig_i & d_q;
  assign edge_o = sig_i ^ d_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Pulse-width checker for divided clocks: measures high/low widths in clk
// cycles, locks after a run of matching periods, flags errors once locked.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int ERR_W       = ERR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [CNT_W-1:0] exp_low,
  output logic [CNT_W-1:0] meas_high,
  output logic [CNT_W-1:0] meas_low,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int GW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic rise_w, fall_w, edge_w;

  div_edge_detect u_edge (
    .clk_i  (clk),
    .rst_ni (rst),
    .sig_i  (div_in),
    .rise_o (rise_w),
    .fall_o (fall_w),
    .edge_o (edge_w)
  );

  mon_state_t       state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] meas_high_q, meas_high_d;
  logic [CNT_W-1:0] meas_low_q, meas_low_d;
  logic [GW-1:0]    good_q, good_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             pv_q, pv_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;

  logic [CNT_W-1:0] run_inc;
  logic [ERR_W-1:0] err_inc;
  logic [GW-1:0]    good_inc;
  logic             period_ok, stuck, lock_fault;

  assign run_inc   = CNT_W'(sat_inc(32'(run_cnt_q), 32'(CNT_MAX)));
  assign err_inc   = ERR_W'(sat_inc(32'(err_cnt_q), 32'(ERR_MAX)));
  assign good_inc  = good_q + GW'(1);
  // At a rise, meas_high_q still holds the high width captured at the
  // preceding fall and run_cnt_q is the low segment that just ended.
  assign period_ok = (meas_high_q == exp_high) && (run_cnt_q == exp_low);
  // A saturated count that coincides with an edge is a legal max-width segment.
  assign stuck     = (run_cnt_q == CNT_MAX) && !edge_w;

  // Next-state: enable override, segment counting, capture and lock FSM.
  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    meas_high_d = meas_high_q;
    meas_low_d  = meas_low_q;
    good_d      = good_q;
    err_cnt_d   = err_cnt_q;
    locked_d    = locked_q;
    pv_d        = 1'b0;
    err_d       = 1'b0;
    lock_fault  = 1'b0;

    if (!en) begin
      state_d   = IDLE;
      run_cnt_d = '0;
      good_d    = '0;
      locked_d  = 1'b0;
    end else if (state_q == IDLE) begin
      state_d   = SYNC;
      run_cnt_d = '0;
    end else begin
      run_cnt_d = edge_w ? CNT_W'(1) : run_inc;
      if (fall_w) meas_high_d = run_cnt_q;
      if (rise_w) meas_low_d  = run_cnt_q;

      case (state_q)
        SYNC: begin
          // First rise closes the partial segment; nothing is compared.
          if (rise_w) state_d = ACQ;
        end
        ACQ: begin
          if (rise_w) begin
            pv_d = 1'b1;
            if (period_ok) begin
              good_d = good_inc;
              if (good_inc == GW'(LOCK_CYCLES)) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              good_d = '0;
            end
          end else if (stuck) begin
            state_d = SYNC;
            good_d  = '0;
          end
        end
        LOCKED: begin
          if (rise_w) begin
            pv_d = 1'b1;
            if (!period_ok) lock_fault = 1'b1;
          end else if (fall_w) begin
            // Early flag: a bad high width is caught before the period ends.
            if (run_cnt_q != exp_high) lock_fault = 1'b1;
          end else if (stuck) begin
            state_d   = SYNC;
            good_d    = '0;
            locked_d  = 1'b0;
            err_d     = 1'b1;
            err_cnt_d = err_inc;
          end
        end
        default: ;
      endcase

      if (lock_fault) begin
        state_d   = ACQ;
        good_d    = '0;
        locked_d  = 1'b0;
        err_d     = 1'b1;
        err_cnt_d = err_inc;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      run_cnt_q   <= '0;
      meas_high_q <= '0;
      meas_low_q  <= '0;
      good_q      <= '0;
      err_cnt_q   <= '0;
      pv_q        <= 1'b0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      meas_high_q <= meas_high_d;
      meas_low_q  <= meas_low_d;
      good_q      <= good_d;
      err_cnt_q   <= err_cnt_d;
      pv_q        <= pv_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
    end
  end

  assign meas_high    = meas_high_q;
  assign meas_low     = meas_low_q;
  assign period_valid = pv_q;
  assign locked       = locked_q;
  assign err          = err_q;
  assign err_cnt      = err_cnt_q;

endmodule
